uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver in the serial-interface group. Configurable data width, parity and stop-bit count. Reports each received frame with a one-cycle valid strobe plus parity and framing error flags. Sits between the board RX pin and byte-level consumers such as command parsers and FIFOs.

---
 rtl/uart_rx_cfg.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF input synchronizer, mid-bit sampling, optional parity,
// one or two stop bits, per-frame valid strobe with parity/framing error flags.
module uart_rx_cfg #(
    parameter int CLK_PER_BIT = 833,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF      = CNT_W'((CLK_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_WAIT_HIGH = 3'd6;

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 out_perr_q, out_perr_d;
    logic                 out_ferr_q, out_ferr_d;
    logic                 par_xor;

    assign rx_s    = sync_q[1];
    assign par_xor = (^shift_q) ^ rx_s;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        out_perr_d = out_perr_q;
        out_ferr_d = out_ferr_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY == 1) ? ~par_xor : par_xor;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rx_s;
                    if (stop_q == LAST_STOP) begin
                        // Outputs are loaded here so they are already visible while o_valid is high.
                        state_d    = S_DONE;
                        valid_d    = 1'b1;
                        data_d     = shift_q;
                        out_perr_d = perr_q;
                        out_ferr_d = ferr_q | ~rx_s;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:      state_d = out_ferr_q ? S_WAIT_HIGH : S_IDLE;
            S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            out_perr_q <= 1'b0;
            out_ferr_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], i_rx};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            out_perr_q <= out_perr_d;
            out_ferr_q <= out_ferr_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = out_perr_q;
    assign o_frame_err  = out_ferr_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four instances (8N1, 8E1, 7N2, 8O1) at 16 clocks per bit,
// each on its own RX line; a negedge monitor logs every o_valid strobe for the checks.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct {
        int         ch;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        int         cyc;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rx_line;

    logic [7:0] d0, d1, d3;
    logic [6:0] d2;
    logic       v0, v1, v2, v3;
    logic       pe0, pe1, pe2, pe3;
    logic       fe0, fe1, fe2, fe3;
    logic       b0, b1, b2, b3;

    int   cyc = 0;
    int   drop_cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    rec_t recs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[0]), .o_data(d0), .o_valid(v0),
        .o_parity_err(pe0), .o_frame_err(fe0), .o_busy(b0));
    uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[1]), .o_data(d1), .o_valid(v1),
        .o_parity_err(pe1), .o_frame_err(fe1), .o_busy(b1));
    uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[2]), .o_data(d2), .o_valid(v2),
        .o_parity_err(pe2), .o_frame_err(fe2), .o_busy(b2));
    uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[3]), .o_data(d3), .o_valid(v3),
        .o_parity_err(pe3), .o_frame_err(fe3), .o_busy(b3));

    always @(negedge clk) begin
        if (v0) recs.push_back('{ch: 0, data: 9'(d0), pe: pe0, fe: fe0, cyc: cyc});
        if (v1) recs.push_back('{ch: 1, data: 9'(d1), pe: pe1, fe: fe1, cyc: cyc});
        if (v2) recs.push_back('{ch: 2, data: 9'(d2), pe: pe2, fe: fe2, cyc: cyc});
        if (v3) recs.push_back('{ch: 3, data: 9'(d3), pe: pe3, fe: fe3, cyc: cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int ch, input logic b);
        rx_line[ch] = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int ch, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit,
                              input int nstop, input logic stop_bit);
        drop_cyc = cyc;
        send_bit(ch, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(ch, data[i]);
        if (has_par) send_bit(ch, par_bit);
        for (int i = 0; i < nstop; i++) send_bit(ch, stop_bit);
    endtask

    task automatic idle_bits(input int ch, input int n);
        rx_line[ch] = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic check_rec(input string tag, input int idx, input int ch,
                             input logic [8:0] data, input logic pe, input logic fe);
        if (recs.size() > idx) begin
            check({tag, "_ch"},   recs[idx].ch,   ch);
            check({tag, "_data"}, recs[idx].data, data);
            check({tag, "_perr"}, recs[idx].pe,   pe);
            check({tag, "_ferr"}, recs[idx].fe,   fe);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_busy;

        rx_line = 4'hF;
        rst_n   = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data", d0, 8'h00);
        check("rst_valid", {v0, v1, v2, v3}, 4'b0);
        check("rst_perr", {pe0, pe1, pe2, pe3}, 4'b0);
        check("rst_ferr", {fe0, fe1, fe2, fe3}, 4'b0);
        check("rst_busy", {b0, b1, b2, b3}, 4'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5. Line low in cycle k: rx_s low at k+2 (t0), last stop sample at
        // t0+1+7+9*16 = k+154, o_valid in the following cycle k+155.
        recs.delete();
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(0, 2);
        check("a5_count", recs.size(), 1);
        check_rec("a5", 0, 0, 9'h0A5, 1'b0, 1'b0);
        if (recs.size() > 0) check("a5_latency", recs[0].cyc - drop_cyc, 155);
        check("a5_busy_idle", b0, 1'b0);

        // 0x37 has five ones: even parity bit is 1, odd parity bit is 0.
        recs.delete();
        send_frame(1, 9'h037, 8, 1'b1, 1'b1, 1, 1'b1);
        idle_bits(1, 2);
        send_frame(1, 9'h037, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1, 2);
        check("even_count", recs.size(), 2);
        check_rec("even_ok", 0, 1, 9'h037, 1'b0, 1'b0);
        check_rec("even_bad", 1, 1, 9'h037, 1'b1, 1'b0);

        recs.delete();
        send_frame(3, 9'h037, 8, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(3, 2);
        send_frame(3, 9'h037, 8, 1'b1, 1'b1, 1, 1'b1);
        idle_bits(3, 2);
        check("odd_count", recs.size(), 2);
        check_rec("odd_ok", 0, 3, 9'h037, 1'b0, 1'b0);
        check_rec("odd_bad", 1, 3, 9'h037, 1'b1, 1'b0);

        // Stop bit low, then the line stays low (break) for 40 bit times.
        recs.delete();
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        check("brk_count", recs.size(), 1);
        check_rec("brk", 0, 0, 9'h05A, 1'b0, 1'b1);
        check("brk_busy_low", b0, 1'b1);
        idle_bits(0, 2);
        check("brk_busy_released", b0, 1'b0);
        recs.delete();
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(0, 2);
        check("after_brk_count", recs.size(), 1);
        check_rec("after_brk", 0, 0, 9'h012, 1'b0, 1'b0);

        // Five-cycle glitch is shorter than the half-bit start check.
        recs.delete();
        seen_busy = 1'b0;
        rx_line[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx_line[0] = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (b0) seen_busy = 1'b1;
        end
        check("glitch_busy_seen", seen_busy, 1'b1);
        check("glitch_busy_end", b0, 1'b0);
        check("glitch_count", recs.size(), 0);

        // 7N2 frames back-to-back with no idle gap.
        recs.delete();
        send_frame(2, 9'h041, 7, 1'b0, 1'b0, 2, 1'b1);
        send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 2, 1'b1);
        send_frame(2, 9'h000, 7, 1'b0, 1'b0, 2, 1'b1);
        idle_bits(2, 2);
        check("b2b_count", recs.size(), 3);
        check_rec("b2b_0", 0, 2, 9'h041, 1'b0, 1'b0);
        check_rec("b2b_1", 1, 2, 9'h07F, 1'b0, 1'b0);
        check_rec("b2b_2", 2, 2, 9'h000, 1'b0, 1'b0);

        // Reset mid-way through data bit 6 of 0xC3; bits 6 and 7 are high so no false start follows.
        recs.delete();
        fork
            send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (7 * CPB + CPB / 2) @(negedge clk);
                check("pre_rst_busy", b0, 1'b1);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("mid_rst_data", d0, 8'h00);
                check("mid_rst_flags", {v0, pe0, fe0}, 3'b000);
                check("mid_rst_busy", b0, 1'b0);
            end
        join
        idle_bits(0, 2);
        check("mid_rst_count", recs.size(), 0);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(0, 2);
        check("post_rst_count", recs.size(), 1);
        check_rec("post_rst", 0, 0, 9'h03C, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
